// File: rtl/mem_bus_seq.sv
// Memory bus sequencer: arbitrates MMU-translated fetch and data word requests onto an
// 8-bit external bus as lo/hi byte cycles, returning read data or a bus-timeout error.
module mem_bus_seq #(
    parameter int unsigned PA      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [PA-2:0] i_addr,
    output logic          i_ack,
    output logic [15:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_write,
    input  logic [1:0]    d_be,
    input  logic [PA-2:0] d_addr,
    input  logic [15:0]   d_wdata,
    output logic          d_ack,
    output logic [15:0]   d_rdata,
    output logic          d_err,
    input  logic          mmu_fault,
    output logic [PA-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [2:0] {StIdle, StLo, StHi, StDone, StErr} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          src_q, src_d;        // 1: data port, 0: fetch port
    logic [PA-2:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [1:0]    be_q, be_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   buf_q, buf_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [PA-1:0] mem_addr_q, mem_addr_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic [15:0]   i_rdata_q, i_rdata_d;
    logic [15:0]   d_rdata_q, d_rdata_d;

    // Candidate request in IDLE; data has priority over fetch.
    logic          acc_valid;
    logic          acc_src;
    logic [PA-2:0] acc_addr;
    logic          acc_write;
    logic [1:0]    acc_be;
    logic [15:0]   acc_wdata;

    assign acc_valid = ~mmu_fault & (d_req | i_req);
    assign acc_src   = d_req;
    assign acc_addr  = d_req ? d_addr : i_addr;
    assign acc_write = d_req & d_write;
    assign acc_be    = d_req ? d_be : 2'b11;
    assign acc_wdata = d_req ? d_wdata : 16'h0000;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        addr_d      = addr_q;
        write_d     = write_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (acc_valid) begin
                    src_d   = acc_src;
                    addr_d  = acc_addr;
                    write_d = acc_write;
                    be_d    = acc_be;
                    wdata_d = acc_wdata;
                    buf_d   = 16'h0000;
                    cnt_d   = 8'd0;
                    if (acc_be[0]) begin
                        state_d     = StLo;
                        mem_addr_d  = {acc_addr, 1'b0};
                        mem_wdata_d = acc_wdata[7:0];
                        mem_rd_d    = ~acc_write;
                        mem_wr_d    = acc_write;
                    end else if (acc_be[1]) begin
                        state_d     = StHi;
                        mem_addr_d  = {acc_addr, 1'b1};
                        mem_wdata_d = acc_wdata[15:8];
                        mem_rd_d    = ~acc_write;
                        mem_wr_d    = acc_write;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLo: begin
                if (mem_ready) begin
                    if (!write_q) buf_d[7:0] = mem_rdata;
                    if (be_q[1]) begin
                        state_d     = StHi;
                        cnt_d       = 8'd0;
                        mem_addr_d  = {addr_q, 1'b1};
                        mem_wdata_d = wdata_q[15:8];
                    end else begin
                        state_d  = StDone;
                        mem_rd_d = 1'b0;
                        mem_wr_d = 1'b0;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d  = StErr;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHi: begin
                if (mem_ready) begin
                    if (!write_q) buf_d[15:8] = mem_rdata;
                    state_d  = StDone;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                end else if (cnt_q == CntLast) begin
                    state_d  = StErr;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Return data is loaded on the edge entering DONE so it is valid with the ack.
        if (state_d == StDone) begin
            if (src_d) d_rdata_d = buf_d;
            else       i_rdata_d = buf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            src_q       <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            be_q        <= 2'b00;
            wdata_q     <= 16'h0000;
            buf_q       <= 16'h0000;
            cnt_q       <= 8'd0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            i_rdata_q   <= 16'h0000;
            d_rdata_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign i_ack     = (state_q == StDone) & ~src_q;
    assign d_ack     = (state_q == StDone) &  src_q;
    assign i_err     = (state_q == StErr)  & ~src_q;
    assign d_err     = (state_q == StErr)  &  src_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_seq.sv
// Directed bench for mem_bus_seq: fetch/data sequencing, arbitration, MMU fault,
// bus timeout and reset mid-access, with hand-computed expectations.
module tb_mem_bus_seq;

    localparam int unsigned PA = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [PA-2:0] i_addr;
    logic          i_ack;
    logic [15:0]   i_rdata;
    logic          i_err;
    logic          d_req;
    logic          d_write;
    logic [1:0]    d_be;
    logic [PA-2:0] d_addr;
    logic [15:0]   d_wdata;
    logic          d_ack;
    logic [15:0]   d_rdata;
    logic          d_err;
    logic          mmu_fault;
    logic [PA-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ready;
    logic [7:0]    rd_lo, rd_hi;

    int checks = 0;
    int errors = 0;

    // Bus model: byte returned depends on the byte lane of the address.
    assign mem_rdata = mem_addr[0] ? rd_hi : rd_lo;

    mem_bus_seq #(.PA(PA), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_write   (d_write),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mmu_fault (mmu_fault),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_write = 1'b0;
        d_be = 2'b00; d_addr = '0; d_wdata = 16'h0; mmu_fault = 1'b0;
        mem_ready = 1'b1; rd_lo = 8'h00; rd_hi = 8'h00;
        tick(); tick();
        reset = 1'b0;
        chk("rst_i_ack", {31'd0, i_ack}, 32'd0);
        chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
        chk("rst_errs", {30'd0, i_err, d_err}, 32'd0);
        chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_rdata", {i_rdata, d_rdata}, 32'd0);

        // 1: fetch word
        i_req = 1'b1; i_addr = 15'h1234; rd_lo = 8'hCD; rd_hi = 8'hAB;
        tick();
        chk("t1_lo_addr", {16'd0, mem_addr}, 32'h2468);
        chk("t1_lo_rd", {30'd0, mem_rd, i_ack}, 32'b10);
        tick();
        chk("t1_hi_addr", {16'd0, mem_addr}, 32'h2469);
        chk("t1_hi_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        chk("t1_ack", {31'd0, i_ack}, 32'd1);
        chk("t1_rdata", {16'd0, i_rdata}, 32'hABCD);
        chk("t1_rd_drop", {31'd0, mem_rd}, 32'd0);
        i_req = 1'b0;
        tick();
        chk("t1_ack_pulse", {31'd0, i_ack}, 32'd0);
        chk("t1_rdata_hold", {16'd0, i_rdata}, 32'hABCD);

        // 2: simultaneous data read and fetch; data wins
        d_req = 1'b1; d_write = 1'b0; d_be = 2'b11; d_addr = 15'h0100;
        i_req = 1'b1; i_addr = 15'h0200; rd_lo = 8'h11; rd_hi = 8'h22;
        tick();
        chk("t2_d_lo_addr", {16'd0, mem_addr}, 32'h0200);
        tick();
        chk("t2_d_hi_addr", {16'd0, mem_addr}, 32'h0201);
        tick();
        chk("t2_d_ack", {30'd0, d_ack, i_ack}, 32'b10);
        chk("t2_d_rdata", {16'd0, d_rdata}, 32'h2211);
        d_req = 1'b0;
        tick();
        chk("t2_gap", {31'd0, mem_rd}, 32'd0);
        tick();
        chk("t2_i_lo", {15'd0, mem_rd, mem_addr}, 32'h1_0400);
        tick();
        chk("t2_i_hi", {15'd0, mem_rd, mem_addr}, 32'h1_0401);
        tick();
        chk("t2_i_ack", {31'd0, i_ack}, 32'd1);
        chk("t2_i_rdata", {16'd0, i_rdata}, 32'h2211);
        i_req = 1'b0;
        tick();

        // 3: hi-only write
        d_req = 1'b1; d_write = 1'b1; d_be = 2'b10; d_addr = 15'h0010; d_wdata = 16'h5A00;
        tick();
        chk("t3_wr", {30'd0, mem_wr, mem_rd}, 32'b10);
        chk("t3_addr", {16'd0, mem_addr}, 32'h0021);
        chk("t3_wdata", {24'd0, mem_wdata}, 32'h5A);
        tick();
        chk("t3_ack", {29'd0, d_ack, mem_wr, mem_rd}, 32'b100);
        d_req = 1'b0; d_write = 1'b0;
        tick();

        // 4: request blocked by MMU fault, accepted once cleared
        mmu_fault = 1'b1; d_req = 1'b1; d_be = 2'b01; d_addr = 15'h0030; rd_lo = 8'h77;
        tick();
        chk("t4_blk1", {30'd0, mem_rd, d_ack}, 32'd0);
        tick();
        chk("t4_blk2", {30'd0, mem_rd, d_ack}, 32'd0);
        mmu_fault = 1'b0;
        tick();
        chk("t4_lo", {15'd0, mem_rd, mem_addr}, 32'h1_0060);
        tick();
        chk("t4_ack", {31'd0, d_ack}, 32'd1);
        chk("t4_rdata", {16'd0, d_rdata}, 32'h0077);
        d_req = 1'b0;
        tick();

        // 5: bus timeout with TIMEOUT=4
        mem_ready = 1'b0; d_req = 1'b1; d_be = 2'b11; d_addr = 15'h0040;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("t5_hold%0d", c), {29'd0, mem_rd, d_err, d_ack}, 32'b100);
        end
        tick();
        chk("t5_err", {29'd0, mem_rd, d_err, d_ack}, 32'b010);
        d_req = 1'b0; mem_ready = 1'b1;
        tick();
        chk("t5_err_pulse", {31'd0, d_err}, 32'd0);
        d_req = 1'b1; rd_lo = 8'h34; rd_hi = 8'h12;
        tick(); tick(); tick();
        chk("t5_recover", {15'd0, d_ack, d_rdata}, 32'h1_1234);
        d_req = 1'b0;
        tick();

        // 6: reset while in HI
        i_req = 1'b1; i_addr = 15'h0050;
        tick(); tick();
        chk("t6_in_hi", {15'd0, mem_rd, mem_addr}, 32'h1_00A1);
        reset = 1'b1;
        tick();
        chk("t6_rst_strobe", {28'd0, mem_rd, mem_wr, i_ack, i_err}, 32'd0);
        reset = 1'b0; i_req = 1'b0;
        tick();
        chk("t6_no_ack", {28'd0, mem_rd, i_ack, i_err, d_ack}, 32'd0);
        i_req = 1'b1; i_addr = 15'h0001;
        tick();
        chk("t6_idle_accept", {15'd0, mem_rd, mem_addr}, 32'h1_0002);
        i_req = 1'b0;
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
